// File: rtl/seq_divider_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// The control unit drives the request side and the divider drives the results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_start;
  logic             in_signed;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_busy;
  logic             out_done;
  logic             out_div_by_zero;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;

  modport master (
    output in_start, in_signed, in_dividend, in_divisor,
    input  out_busy, out_done, out_div_by_zero, out_quotient, out_remainder
  );

  modport slave (
    input  in_start, in_signed, in_dividend, in_divisor,
    output out_busy, out_done, out_div_by_zero, out_quotient, out_remainder
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with signed/unsigned mode, start/busy/done handshake
// and divide-by-zero detection; one quotient bit per clock.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          in_reset,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] ITERATIONS = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;

  assign dividend_neg = bus.in_signed & bus.in_dividend[WIDTH-1];
  assign divisor_neg  = bus.in_signed & bus.in_divisor[WIDTH-1];
  assign dividend_mag = dividend_neg ? -bus.in_dividend : bus.in_dividend;
  assign divisor_mag  = divisor_neg  ? -bus.in_divisor  : bus.in_divisor;

  // The shifted partial remainder can reach 2*M-1, so the trial subtraction
  // keeps one extra bit; its MSB is the borrow.
  always_comb begin
    a_sh  = {a, q[WIDTH-1]};
    trial = a_sh - {1'b0, m};
  end

  // NOTE: every register here is state, so all assignments are non-blocking;
  // the asynchronous reset branch clears the whole datapath, not just the FSM.
  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state               <= IDLE;
      a                   <= '0;
      q                   <= '0;
      m                   <= '0;
      cnt                 <= '0;
      neg_q               <= 1'b0;
      neg_r               <= 1'b0;
      dz                  <= 1'b0;
      bus.out_busy        <= 1'b0;
      bus.out_done        <= 1'b0;
      bus.out_div_by_zero <= 1'b0;
      bus.out_quotient    <= '0;
      bus.out_remainder   <= '0;
    end else begin
      bus.out_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_start) begin
            bus.out_busy <= 1'b1;
            neg_q        <= dividend_neg ^ divisor_neg;
            neg_r        <= dividend_neg;
            a            <= '0;
            m            <= divisor_mag;
            cnt          <= ITERATIONS;
            if (bus.in_divisor == '0) begin
              // Q keeps the raw dividend so FIX can hand it back unmodified.
              dz    <= 1'b1;
              q     <= bus.in_dividend;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              q     <= dividend_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            a <= trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            a <= a_sh[WIDTH-1:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            bus.out_quotient    <= '1;
            bus.out_remainder   <= q;
            bus.out_div_by_zero <= 1'b1;
          end else begin
            bus.out_quotient    <= neg_q ? -q : q;
            bus.out_remainder   <= neg_r ? -a : a;
            bus.out_div_by_zero <= 1'b0;
          end
          bus.out_done <= 1'b1;
          bus.out_busy <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider for the Mini-SRC datapath. It is the successor to the fixed 32-bit reset-started divider.
- Adds generic width, a runtime signed/unsigned mode, a start/busy/done handshake, correct quotient and remainder sign fix-up, and divide-by-zero detection.
- Sits beside the ALU and feeds the HI/LO registers. The control unit pulses start, then waits for done.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- in_reset  in  1  asynchronous reset, active-high
- in_start  in  1  start request, sampled on rising clk
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_dividend  in  WIDTH  dividend, sampled with start
- in_divisor  in  WIDTH  divisor, sampled with start
- out_busy  out  1  high while an operation is in progress
- out_done  out  1  one-cycle pulse when results update
- out_div_by_zero  out  1  set with done when divisor was zero; held until next done
- out_quotient  out  WIDTH  quotient, held until next done
- out_remainder  out  WIDTH  remainder, held until next done

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE; out_busy=0, out_done=0, out_div_by_zero=0, out_quotient=0, out_remainder=0; internal A/Q/M/counter/sign flags cleared; any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - in_start=1 at edge E0: capture operands and latch in_signed.
  - In signed mode, take the magnitude of any negative operand: |x| = ~x+1, with x treated as unsigned WIDTH bits.
  - Record neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend). Both are 0 in unsigned mode.
  - A=0, Q=|dividend|, M=|divisor|, counter=WIDTH.
  - out_busy=1. Go to CALC, or to FIX directly if divisor==0.
- CALC (one iteration per edge):
  - {A,Q} <<= 1, then T = A − M.
  - If T ≥ 0 (unsigned, WIDTH+1-bit compare): A=T, Q[0]=1. Otherwise A unchanged, Q[0]=0.
  - counter decrements each iteration; after the WIDTH-th iteration go to FIX.
- FIX, one edge:
  - out_quotient = neg_q ? −Q : Q.
  - out_remainder = neg_r ? −A : A.
  - out_div_by_zero=0, out_done=1, out_busy=0, go to IDLE.
- Divide by zero (divisor==0 at capture): skip CALC.
  - FIX loads out_quotient = all ones, out_remainder = dividend as given (unmodified), out_div_by_zero=1.
- Latency:
  - Normal: done visible in the cycle after edge E0+WIDTH+1, i.e. WIDTH+1 edges after the start edge.
  - Divide by zero: done visible after edge E0+1.
  - out_busy is high from after E0 until done asserts.
- out_done: exactly one cycle wide. It deasserts on the next edge regardless of in_start.
- Back-to-back: in_start high in the cycle done is high is accepted (state is IDLE). That edge captures the new operands and clears done.
- in_start while busy: ignored. Operand changes while busy have no effect. out_quotient and out_remainder keep previous results until the FIX edge.
- Semantics:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - |remainder| < |divisor|; dividend = quotient·divisor + remainder (mod 2^WIDTH).
- Overflow: signed MIN / −1 gives quotient = MIN (wraps), remainder = 0, no flag.
- Unsigned mode: operands are never negated. 0xFFFFFFFF / 2 gives quotient 0x7FFFFFFF, remainder 1.
- All arithmetic is WIDTH bits, except the trial subtraction, which is WIDTH+1 bits.

Test Plan (WIDTH=32 unless stated):
1. Signed sign cases, each started with a start pulse and checked at done:
   - 30/4 → q=7, r=2
   - 10/−3 → q=0xFFFFFFFD, r=1
   - −500/3 → q=0xFFFFFF5A (−166), r=0xFFFFFFFE (−2)
   - −100/−9 → q=11, r=0xFFFFFFFF (−1)
   - done occurs exactly 33 edges after the start edge in each case.
2. Unsigned vs signed: 0xFFFFFFFF/2:
   - in_signed=0 → q=0x7FFFFFFF, r=1
   - in_signed=1 → q=0, r=0xFFFFFFFF
3. Edge values:
   - 5/0 → done after 1 edge, div_by_zero=1, q=0xFFFFFFFF, r=5
   - 0x80000000/0xFFFFFFFF signed → q=0x80000000, r=0, div_by_zero=0
   - 0/7 → q=0, r=0
4. Handshake:
   - Pulse start with 100/7, then assert start again with 9/3 at cycle 10 (mid-operation) → second start ignored; result q=14, r=2.
   - Start 9/3 in the done cycle → accepted; q=3, r=0 after 33 more edges.
   - out_done is one cycle wide in both cases.
5. Reset mid-operation:
   - Assert in_reset asynchronously (not edge-aligned) at cycle 15 of 1000/7 → all outputs 0 immediately, state IDLE.
   - A fresh 1000/7 then yields q=142, r=6.
6. Parameter sweep: WIDTH=8 and WIDTH=16, random signed and unsigned operands (≥1000 each) against a reference model.
   - Checks: latency WIDTH+1 edges, dividend == q·d + r, |r| < |d|, sign(r) == sign(dividend).
